frame_sequencer: RTL and testbench

- Generates the 512 Hz frame-sequencer timing strobes for the 4-channel audio unit: length_tick, sweep_tick and envelope_tick.
- Consumes the power-on restart pulse produced by the audio power-control stage (NR52[7] rising-edge detector) plus the NR52[7] master enable.
- Its strobes feed the length counters, channel-1 sweep unit and envelope units of channels 1, 2 and 4.

---
 rtl/audio_pkg.sv | 9 +
 rtl/tick_divider.sv | 24 ++
 rtl/frame_sequencer.sv | 76 +++++++
 tb/tb_frame_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared step constants and types for the audio frame sequencer
package audio_pkg;
    localparam int STEP_W           = 3;
    localparam int TICK_DIV_DEFAULT = 32768;
    typedef logic [STEP_W-1:0] step_t;
    localparam step_t STEP_SWEEP_A  = 3'd2;
    localparam step_t STEP_SWEEP_B  = 3'd6;
    localparam step_t STEP_ENV      = 3'd7;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: modulo-N counter with synchronous clear/enable and a combinational wrap pulse
module tick_divider #(
    parameter int N = 32768,
    parameter int W = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    assign cnt  = cnt_q;
    assign wrap = en && !clr && (cnt_q == W'(N - 1));
    // next count: restart from zero on wrap, otherwise advance when enabled
    always_comb cnt_d = wrap ? '0 : (en ? cnt_q + W'(1) : cnt_q);
    // counter register; clear takes priority over counting
    always_ff @(posedge clock) begin
        if (reset || clr) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: 512 Hz length/sweep/envelope strobes; FRAME_SEQ_FRAME_CNT_EN adds a frame_cnt debug port
module frame_sequencer
    import audio_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DIV_W    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    input  logic        master_en,
    output logic        length_tick,
    output logic        sweep_tick,
    output logic        envelope_tick,
`ifdef FRAME_SEQ_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output step_t       step
);
    logic             clr;
    logic             wrap;
    logic [DIV_W-1:0] div_q;
    step_t            step_q, step_d;
    logic             len_q, len_d, swp_q, swp_d, env_q, env_d;

    // restart and a disabled master both freeze and clear the sequencer
    assign clr           = restart || !master_en;
    assign step          = step_q;
    assign length_tick   = len_q;
    assign sweep_tick    = swp_q;
    assign envelope_tick = env_q;

    tick_divider #(.N(TICK_DIV), .W(DIV_W)) u_div (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .en    (1'b1),
        .cnt   (div_q),
        .wrap  (wrap)
    );

    // decode the step being executed on a divider wrap into strobes
    always_comb begin
        step_d = wrap ? step_t'(step_q + 3'd1) : step_q;
        len_d  = wrap && !step_q[0];
        swp_d  = wrap && (step_q == STEP_SWEEP_A || step_q == STEP_SWEEP_B);
        env_d  = wrap && (step_q == STEP_ENV);
    end

    // step index and registered one-cycle strobes
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            step_q <= '0;
            len_q  <= 1'b0;
            swp_q  <= 1'b0;
            env_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            len_q  <= len_d;
            swp_q  <= swp_d;
            env_q  <= env_d;
        end
    end

`ifdef FRAME_SEQ_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
    assign frame_cnt = fc_q;
    // a frame completes when step 7 executes; count saturates at all ones
    always_comb fc_d = (wrap && step_q == STEP_ENV && fc_q != 16'hFFFF) ? fc_q + 16'd1 : fc_q;
    // saturating completed-frame counter
    always_ff @(posedge clock) begin
        if (reset || clr) fc_q <= '0;
        else              fc_q <= fc_d;
    end
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scoreboard bench for frame_sequencer with TICK_DIV=4
module tb_frame_sequencer;
    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       master_en = 1'b1;
    logic       length_tick, sweep_tick, envelope_tick;
    logic [2:0] step;
`ifdef FRAME_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int cyc = 0, checks = 0, errors = 0;
    int n_l = 0, n_s = 0, n_e = 0;

    typedef struct {
        int         c;
        logic [2:0] t;
        logic [2:0] s;
    } ev_t;
    ev_t q[$];
    ev_t e;

    // strobes {length, sweep, envelope} produced when step k executes
    logic [2:0] pat [8] = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};

    frame_sequencer #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .restart       (restart),
        .master_en     (master_en),
        .length_tick   (length_tick),
        .sweep_tick    (sweep_tick),
        .envelope_tick (envelope_tick),
`ifdef FRAME_SEQ_FRAME_CNT_EN
        .frame_cnt     (frame_cnt),
`endif
        .step          (step)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clock);
            #2;
        end
    endtask

    // last clearing cycle is base: step k strobes appear in cycle base+TD+1+TD*k
    task automatic expect_frames(int base, int k0, int k1);
        for (int k = k0; k <= k1; k++)
            if (pat[k % 8] != 3'b000)
                q.push_back('{base + TD + 1 + TD * k, pat[k % 8], 3'((k + 1) % 8)});
    endtask

    always @(negedge clock) begin
        if (length_tick) n_l++;
        if (sweep_tick) n_s++;
        if (envelope_tick) n_e++;
        while (q.size() > 0 && q[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_tick cycle %0d: got none expected %b", q[0].c, q[0].t);
            void'(q.pop_front());
        end
        if ({length_tick, sweep_tick, envelope_tick} != 3'b000) begin
            if (q.size() == 0 || q[0].c != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick cycle %0d: got %b expected none", cyc,
                         {length_tick, sweep_tick, envelope_tick});
            end else begin
                e = q.pop_front();
                check("tick_pattern", int'({length_tick, sweep_tick, envelope_tick}), int'(e.t));
                check("tick_step", int'(step), int'(e.s));
            end
        end
    end

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, t7, fin, l0, s0, e0;
        goto(2);
        t0 = 2;
        check("reset_step", int'(step), 0);
        check("reset_ticks", int'({length_tick, sweep_tick, envelope_tick}), 0);
        expect_frames(t0, 0, 12);
        goto(3);
        reset = 1'b0;

        t1 = t0 + 54;
        goto(t1);
        check("step_before_restart", int'(step), 5);
        restart = 1'b1;
        goto(t1 + 1);
        restart = 1'b0;
        check("step_after_restart", int'(step), 0);
        expect_frames(t1, 0, 1);

        t2 = t1 + 10;
        goto(t2);
        master_en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            goto(t2 + i);
            check("step_frozen", int'(step), 0);
        end
        t3 = t2 + 20;
        master_en = 1'b1;
        expect_frames(t3 - 1, 0, 18);
        l0 = n_l;
        s0 = n_s;
        e0 = n_e;

        t4 = t3 + 80;
        goto(t4);
        check("count_length", n_l - l0, 10);
        check("count_sweep", n_s - s0, 5);
        check("count_envelope", n_e - e0, 2);

        t5 = t4 + 3;
        goto(t5);
        restart = 1'b1;
        goto(t5 + 1);
        restart = 1'b0;
        expect_frames(t5, 0, 1);

        t6 = t5 + 12;
        goto(t6);
        master_en = 1'b0;
        goto(t6 + 1);
        master_en = 1'b1;
        check("step_after_en_drop", int'(step), 0);
        expect_frames(t6, 0, 3);

        t7 = t6 + 20;
        goto(t7);
        restart = 1'b1;
        goto(t7 + 1);
        restart = 1'b0;
        check("step_after_wrap_restart", int'(step), 0);
`ifdef FRAME_SEQ_FRAME_CNT_EN
        check("frame_cnt_cleared", int'(frame_cnt), 0);
        expect_frames(t7, 0, 23);
        goto(t7 + 100);
        check("frame_cnt_three", int'(frame_cnt), 3);
        restart = 1'b1;
        goto(t7 + 101);
        restart = 1'b0;
        check("frame_cnt_restart", int'(frame_cnt), 0);
        expect_frames(t7 + 100, 0, 0);
        fin = t7 + 108;
`else
        expect_frames(t7, 0, 3);
        fin = t7 + 18;
`endif
        goto(fin);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
